// File: rtl/bus_endpoint_if.sv
// Signal bundle between a bus endpoint (slave side) and the device/arbiter pair
// that drives it (master side).
interface bus_endpoint_if #(
  parameter int pckg_sz = 16
);
  logic               tx_valid;
  logic [pckg_sz-1:0] tx_data;
  logic               tx_ready;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               rx_valid;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_pop;
  logic [7:0]         drop_cnt;
  logic [7:0]         miss_cnt;
  logic               err_pop;

  modport slave (
    input  tx_valid, tx_data, pop, push, D_push, rx_pop,
    output tx_ready, pndng, D_pop, rx_valid, rx_data, drop_cnt, miss_cnt, err_pop
  );

  modport master (
    output tx_valid, tx_data, pop, push, D_push, rx_pop,
    input  tx_ready, pndng, D_pop, rx_valid, rx_data, drop_cnt, miss_cnt, err_pop
  );
endinterface

// File: rtl/bus_endpoint.sv
// Device-side terminal of the broadcast bus: a TX FIFO feeding the arbiter and an
// address-filtered RX FIFO feeding the device, both first-word-fall-through.
module bus_endpoint #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic          clk,
  input  logic          reset,
  bus_endpoint_if.slave bus
);

  localparam int AW = $clog2(depth);

  typedef logic [AW-1:0]      ptr_t;
  typedef logic [AW:0]        cnt_t;
  typedef logic [pckg_sz-1:0] pkt_t;

  localparam cnt_t CNT_FULL = cnt_t'(depth);
  localparam cnt_t CNT_ZERO = cnt_t'(0);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam pkt_t PKT_ZERO = pkt_t'(0);

  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + PTR_ONE;
  endfunction

  function automatic cnt_t cnt_next(input cnt_t c, input logic wr, input logic rd);
    cnt_t result;
    case ({wr, rd})
      2'b10:   result = c + CNT_ONE;
      2'b01:   result = c - CNT_ONE;
      default: result = c;
    endcase
    return result;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic en);
    logic [7:0] result;
    if (en && (c != 8'hFF)) begin
      result = c + 8'd1;
    end else begin
      result = c;
    end
    return result;
  endfunction

  pkt_t       tx_mem_r [depth];
  ptr_t       tx_wr_ptr_r;
  ptr_t       tx_rd_ptr_r;
  cnt_t       tx_cnt_r;
  logic       err_pop_r;
  logic       alive_r;

  pkt_t       rx_mem_r [depth];
  ptr_t       rx_wr_ptr_r;
  ptr_t       rx_rd_ptr_r;
  cnt_t       rx_cnt_r;
  logic [7:0] drop_cnt_r;
  logic [7:0] miss_cnt_r;

  logic       tx_empty_s;
  logic       tx_full_s;
  logic       tx_ready_s;
  logic       tx_wr_s;
  logic       tx_rd_s;
  logic       tx_bad_pop_s;
  pkt_t       tx_head_s;

  logic       rx_empty_s;
  logic       rx_full_s;
  logic [7:0] rx_addr_s;
  logic       rx_hit_s;
  logic       rx_wr_s;
  logic       rx_rd_s;
  logic       rx_drop_s;
  logic       rx_miss_s;
  pkt_t       rx_head_s;

  // TX control: readiness comes only from registered state, and alive_r keeps
  // tx_ready low while reset is held.
  always_comb begin
    tx_empty_s   = (tx_cnt_r == CNT_ZERO);
    tx_full_s    = (tx_cnt_r == CNT_FULL);
    tx_ready_s   = alive_r && !tx_full_s;
    tx_wr_s      = bus.tx_valid && tx_ready_s;
    tx_rd_s      = bus.pop && !tx_empty_s;
    tx_bad_pop_s = bus.pop && tx_empty_s;
    if (tx_empty_s) begin
      tx_head_s = PKT_ZERO;
    end else begin
      tx_head_s = tx_mem_r[tx_rd_ptr_r];
    end
  end

  // RX filter: fullness is the registered state, so a same-cycle rx_pop never
  // makes room for this cycle's push.
  always_comb begin
    rx_empty_s = (rx_cnt_r == CNT_ZERO);
    rx_full_s  = (rx_cnt_r == CNT_FULL);
    rx_addr_s  = bus.D_push[pckg_sz-1 -: 8];
    rx_hit_s   = (rx_addr_s == id) || (rx_addr_s == broadcast);
    rx_wr_s    = bus.push && rx_hit_s && !rx_full_s;
    rx_drop_s  = bus.push && rx_hit_s && rx_full_s;
    rx_miss_s  = bus.push && !rx_hit_s;
    rx_rd_s    = bus.rx_pop && !rx_empty_s;
    if (rx_empty_s) begin
      rx_head_s = PKT_ZERO;
    end else begin
      rx_head_s = rx_mem_r[rx_rd_ptr_r];
    end
  end

  assign bus.tx_ready = tx_ready_s;
  assign bus.pndng    = !tx_empty_s;
  assign bus.D_pop    = tx_head_s;
  assign bus.err_pop  = err_pop_r;
  assign bus.rx_valid = !rx_empty_s;
  assign bus.rx_data  = rx_head_s;
  assign bus.drop_cnt = drop_cnt_r;
  assign bus.miss_cnt = miss_cnt_r;

  // TX FIFO storage, pointers and the sticky empty-pop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        tx_mem_r[i] <= PKT_ZERO;
      end
      tx_wr_ptr_r <= ptr_t'(0);
      tx_rd_ptr_r <= ptr_t'(0);
      tx_cnt_r    <= CNT_ZERO;
      err_pop_r   <= 1'b0;
      alive_r     <= 1'b0;
    end else begin
      alive_r <= 1'b1;
      if (tx_wr_s) begin
        tx_mem_r[tx_wr_ptr_r] <= bus.tx_data;
        tx_wr_ptr_r           <= ptr_inc(tx_wr_ptr_r);
      end
      if (tx_rd_s) begin
        tx_rd_ptr_r <= ptr_inc(tx_rd_ptr_r);
      end
      tx_cnt_r <= cnt_next(tx_cnt_r, tx_wr_s, tx_rd_s);
      if (tx_bad_pop_s) begin
        err_pop_r <= 1'b1;
      end
    end
  end

  // RX FIFO storage, pointers and the saturating drop/miss counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        rx_mem_r[i] <= PKT_ZERO;
      end
      rx_wr_ptr_r <= ptr_t'(0);
      rx_rd_ptr_r <= ptr_t'(0);
      rx_cnt_r    <= CNT_ZERO;
      drop_cnt_r  <= 8'h00;
      miss_cnt_r  <= 8'h00;
    end else begin
      if (rx_wr_s) begin
        rx_mem_r[rx_wr_ptr_r] <= bus.D_push;
        rx_wr_ptr_r           <= ptr_inc(rx_wr_ptr_r);
      end
      if (rx_rd_s) begin
        rx_rd_ptr_r <= ptr_inc(rx_rd_ptr_r);
      end
      rx_cnt_r   <= cnt_next(rx_cnt_r, rx_wr_s, rx_rd_s);
      drop_cnt_r <= sat_inc(drop_cnt_r, rx_drop_s);
      miss_cnt_r <= sat_inc(miss_cnt_r, rx_miss_s);
    end
  end

endmodule

// File: doc/bus_endpoint.md
# bus_endpoint

Per-device terminal for the broadcast bus arbiter: it is the device-side counterpart of the arbiter's FIFO-style port. Outbound packets from a device are buffered in a TX FIFO and presented to the bus through `pndng`/`D_pop`/`pop`. Inbound `push`/`D_push` transfers are address-filtered against this endpoint's ID or the broadcast ID, then buffered in an RX FIFO for the device. One instance sits on each of the `drvrs` bus ports.

## Interface
Parameters:
- `pckg_sz`, 16: packet width in bits; `pckg_sz` ≥ 9.
- `depth`, 8: entries per FIFO (TX and RX each); a power of two, ≥ 2.
- `id`, 0: 8-bit address of this endpoint.
- `broadcast`, 8'hFF: broadcast address.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  device offers packet `tx_data`.
- `tx_data`  in  pckg_sz  outbound packet; bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
- `tx_ready`  out  1  TX FIFO can accept a packet.
- `pndng`  out  1  TX FIFO non-empty (to arbiter).
- `D_pop`  out  pckg_sz  TX FIFO head packet (to arbiter).
- `pop`  in  1  arbiter consumes `D_pop`.
- `push`  in  1  arbiter delivers `D_push`.
- `D_push`  in  pckg_sz  inbound packet.
- `rx_valid`  out  1  RX FIFO non-empty.
- `rx_data`  out  pckg_sz  RX FIFO head packet.
- `rx_pop`  in  1  device consumes `rx_data`.
- `drop_cnt`  out  8  count of matching packets dropped because the RX FIFO was full.
- `miss_cnt`  out  8  count of inbound packets whose address is neither `id` nor `broadcast`.
- `err_pop`  out  1  sticky flag: `pop` was seen with the TX FIFO empty.

## Operation
- **Storage.** Each FIFO is a circular buffer with read and write pointers of width $clog2(depth) and an occupancy count of width $clog2(depth)+1. Pointers wrap from depth-1 to 0.
- **TX write.** `tx_ready` = !tx_full. The write happens when `tx_valid` && `tx_ready`. When full, `tx_ready` stays low even if `pop` is high in the same cycle; the freed slot is visible on the next cycle.
- **TX read.** The TX FIFO is first-word-fall-through.
  - `pndng` = !tx_empty. `D_pop` = head entry, or 0 when empty.
  - `pop` && `pndng`: advance the read pointer.
  - `pop` && !`pndng`: no state change; set `err_pop`, which holds until reset.
- **TX simultaneous write and pop.** Write and pop in the same cycle leave the count unchanged, and both pointers advance.
- **RX filter.**
  - Address field: addr = `D_push`[pckg_sz-1:pckg_sz-8].
  - On `push`: if addr == `id` or addr == `broadcast`, the packet is a match; otherwise `miss_cnt` increments.
  - A match is written to the RX FIFO if it is not full.
  - A match arriving with the RX FIFO full increments `drop_cnt`.
  - Fullness is the registered state. A `rx_pop` in the same cycle does not make room for that cycle's `push`.
- **RX read.** First-word-fall-through. `rx_valid` = !rx_empty. `rx_data` = head entry, or 0 when empty.
  - `rx_pop` && `rx_valid` advances the read pointer.
  - `rx_pop` when empty is ignored.
- **Counters.** Both counters saturate at 8'hFF and never wrap.
- **Reset.** Asserting `reset` low at any time, including mid-transfer, asynchronously clears:
  - pointers, counts, counters and `err_pop`;
  - all FIFO contents, which are discarded.
- **Outputs while reset is low:** `pndng`=0, `D_pop`=0, `rx_valid`=0, `rx_data`=0, `drop_cnt`=0, `miss_cnt`=0, `err_pop`=0, `tx_ready`=0.
- **Outputs after reset release:** `tx_ready`=1.

## Timing
- TX write at edge N: `pndng`=1 and `D_pop`=packet are visible after edge N. The arbiter can sample them at edge N+1, so latency is 1 cycle.
- `pop` sampled at edge N: the next entry, or `pndng`=0, is visible after edge N.
- Back-to-back `pop` on consecutive cycles drains one entry per cycle.
- Matching `push` at edge N: `rx_valid`=1 and `rx_data`=packet are visible after edge N.
- `drop_cnt`, `miss_cnt` and `err_pop` update at the edge on which the event is sampled.
- No combinational path from `pop` to `pndng`/`D_pop`, from `push` to `rx_*`, or from any input to `tx_ready`. The only exception is the asynchronous effect of `reset`.
- Throughput is one packet per cycle per direction, with TX and RX fully independent.

## Test plan
- **Reset.** Drive `reset`=0 for 2 cycles, then release. Required: all outputs 0 during reset, then `tx_ready`=1 and everything else 0.
- **TX ordering and full.** With `depth`=8, write 8 packets 16'h0100..16'h0107 with `pop` held low. Required: `tx_ready`=0 after the 8th write, and a 9th `tx_valid` is not accepted. Then `pop` 8 times on consecutive cycles: `D_pop` shows 0100..0107 in order, and `pndng` drops after the 8th pop.
- **TX simultaneous write/pop and empty pop.** Write and `pop` in the same cycle with 3 entries present. Required: count stays 3. On an empty FIFO, assert `pop`: `err_pop`=1, stays high, and `pndng`=0.
- **RX filter.** With `id`=8'h02, push 16'h0211, then 16'hFF22, then 16'h0333. Required: `rx_data` sequence 0211, FF22; `miss_cnt`=1.
- **RX overflow.** With `rx_pop` low, push 10 matching packets. Required: 8 are stored and `drop_cnt`=2. Next, push a matching packet with `rx_pop` in the same cycle while full: `drop_cnt`=3. Then drive 300 mismatched pushes: `miss_cnt` saturates at 8'hFF.
- **Reset mid-traffic.** Assert `reset` low with 4 TX and 5 RX entries present. Required: `pndng`=0 and `rx_valid`=0 immediately, without waiting for a clock edge. After release, both FIFOs are empty and accept new packets normally.
